// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared state type, default widths and response codes for the AHB-to-APB bridge
package apb_bridge_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NSLV   = 3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_ctr.sv
// rtl/apb_timeout_ctr.sv - ACCESS wait-state counter flagging when the abort limit is reached
module apb_timeout_ctr #(
    parameter int CNT_W = 5
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == limit);

endmodule

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB master FSM driving one SETUP/ACCESS per AHB transfer
// Optional ACCESS timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_master_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NSLV        = DEF_NSLV,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              valid,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [NSLV-1:0]   hsel,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic [NSLV-1:0]   psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_e        state_q, state_d;
    logic              hreadyout_q, hreadyout_d;
    logic              hresp_q, hresp_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic [NSLV-1:0]   psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [NSLV-1:0]   hsel_q, hsel_d;
    logic              accept;
    logic              timeout_hit;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    apb_timeout_ctr #(
        .CNT_W(CNT_W)
    ) u_timeout (
        .hclk   (hclk),
        .hresetn(hresetn),
        .clear  (state_q == SETUP),
        .enable (state_q == ACCESS && !pready),
        .limit  (CNT_W'(TIMEOUT_CYC - 1)),
        .expired(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign accept = valid && hreadyout_q && (state_q == IDLE || state_q == ERR2);

    always_comb begin
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        hsel_d      = hsel_q;

        case (state_q)
            IDLE, ERR2: begin
                state_d     = IDLE;
                hresp_d     = HRESP_OKAY;
                hreadyout_d = 1'b1;
                if (accept) begin
                    paddr_d     = haddr;
                    pwrite_d    = hwrite;
                    hsel_d      = hsel;
                    hreadyout_d = 1'b0;
                    if (hsel == '0) begin
                        state_d = ERR1;
                        hresp_d = HRESP_ERROR;
                    end else if (hwrite) begin
                        state_d = WDATA;
                    end else begin
                        // Reads skip WDATA, so select goes out with the SETUP state itself.
                        state_d = SETUP;
                        psel_d  = hsel;
                    end
                end
            end
            WDATA: begin
                pwdata_d = hwdata;
                psel_d   = hsel_q;
                state_d  = SETUP;
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (pslverr) begin
                        state_d = ERR1;
                        hresp_d = HRESP_ERROR;
                    end else begin
                        state_d     = IDLE;
                        hreadyout_d = 1'b1;
                        if (!pwrite_q) begin
                            hrdata_d = prdata;
                        end
                    end
                end else if (timeout_hit) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ERR1;
                    hresp_d   = HRESP_ERROR;
                end
            end
            ERR1: begin
                state_d     = ERR2;
                hresp_d     = HRESP_ERROR;
                hreadyout_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            hsel_q      <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            hsel_q      <= hsel_d;
        end
    end

    a_hsel_onehot: assert property (@(posedge hclk) disable iff (!hresetn) accept |-> $onehot0(hsel));

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign hrdata    = hrdata_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign psel      = psel_q;
    assign penable   = penable_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - scoreboard bench for apb_master_ctrl with an APB slave model
module tb_apb_master_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic          valid = 1'b0;
    logic          hwrite = 1'b0;
    logic [AW-1:0] haddr = '0;
    logic [NS-1:0] hsel = '0;
    logic [DW-1:0] hwdata = '0;
    logic          hreadyout;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic [NS-1:0] psel;
    logic          penable;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [NS-1:0] sel;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            waits;
        bit            slverr;
    } txn_t;

    typedef struct {
        int            ack_cyc;
        bit            err;
        logic [DW-1:0] hrdata;
    } exp_t;

    exp_t          exp_q[$];
    txn_t          cur;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            wcnt = 0;
    logic [DW-1:0] model_hrdata = '0;
    bit            prev_hready = 1'b1;
    bit            prev_hresp = 1'b0;

    apb_master_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .NSLV(NS), .TIMEOUT_CYC(16)
    ) dut (
        .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite),
        .haddr(haddr), .hsel(hsel), .hwdata(hwdata),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel),
        .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input bit wr, input logic [NS-1:0] sel, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                                input int w, input bit se);
        txn_t t;
        t.write = wr; t.sel = sel; t.addr = a; t.wdata = wd;
        t.rdata = rd; t.waits = w; t.slverr = se;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        logic [NS-1:0] sel;
        sel = ($urandom_range(0, 9) == 0) ? '0 : NS'(1 << $urandom_range(0, NS - 1));
        return mk(1'($urandom), sel, AW'($urandom), DW'($urandom), DW'($urandom),
                  int'($urandom_range(0, 4)), $urandom_range(0, 6) == 0);
    endfunction

    // APB slave model: waits, error and read data come from the transfer in flight.
    always @(negedge hclk) begin
        if (psel != '0 && penable) begin
            check("access_paddr", 64'(paddr), 64'(cur.addr));
            check("access_psel", 64'(psel), 64'(cur.sel));
            check("access_pwrite", 64'(pwrite), 64'(cur.write));
            if (cur.write) check("access_pwdata", 64'(pwdata), 64'(cur.wdata));
            pready  = (wcnt >= cur.waits);
            pslverr = pready && cur.slverr;
            prdata  = pready ? cur.rdata : DW'($urandom);
            wcnt++;
        end else begin
            if (psel != '0) check("setup_psel", 64'(psel), 64'(cur.sel));
            wcnt    = 0;
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = DW'($urandom);
        end
    end

    // Response monitor: every rising hreadyout closes the oldest outstanding transfer.
    exp_t e_mon;
    always @(negedge hclk) begin
        if (!hresetn) begin
            prev_hready = 1'b1;
            prev_hresp  = 1'b0;
        end else begin
            if (hreadyout && !prev_hready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 64'(1), 64'(0));
                end else begin
                    e_mon = exp_q.pop_front();
                    check("ack_cycle", 64'(cyc), 64'(e_mon.ack_cyc));
                    check("ack_hresp", 64'(hresp), 64'(e_mon.err));
                    check("ack_prev_hresp", 64'(prev_hresp), 64'(e_mon.err));
                    check("ack_hrdata", 64'(hrdata), 64'(e_mon.hrdata));
                end
            end
            prev_hready = hreadyout;
            prev_hresp  = hresp;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input txn_t t);
        int   n;
        int   w;
        bit   err;
        exp_t e;
        valid  = 1'b1;
        hwrite = t.write;
        haddr  = t.addr;
        hsel   = t.sel;
        n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (!hreadyout && n < 100);
        if (!hreadyout) begin
            check("accept_timeout", 64'(0), 64'(1));
            valid = 1'b0;
            return;
        end
        cur = t;
        w   = t.waits;
        err = (t.sel == '0) || t.slverr;
`ifdef APB_TIMEOUT_EN
        if (t.sel != '0 && t.waits >= 16) begin
            err = 1'b1;
            w   = 15;
        end
`endif
        if (t.sel == '0) e.ack_cyc = cyc + 2;
        else e.ack_cyc = cyc + (t.write ? 3 : 2) + w + 1 + (err ? 1 : 0);
        if (!err && !t.write) model_hrdata = t.rdata;
        e.err    = err;
        e.hrdata = model_hrdata;
        exp_q.push_back(e);
        @(posedge hclk);
        #1;
        valid  = 1'b0;
        hwdata = t.wdata;
        haddr  = AW'($urandom);
        hwrite = 1'($urandom);
        hsel   = '0;
    endtask

    task automatic gap(input int g);
        repeat (g) begin
            @(posedge hclk);
            #1;
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge hclk);
        check("rst_hreadyout", 64'(hreadyout), 64'(1));
        check("rst_hresp", 64'(hresp), 64'(0));
        check("rst_hrdata", 64'(hrdata), 64'(0));
        check("rst_paddr", 64'(paddr), 64'(0));
        check("rst_pwdata", 64'(pwdata), 64'(0));
        check("rst_pwrite", 64'(pwrite), 64'(0));
        check("rst_psel", 64'(psel), 64'(0));
        check("rst_penable", 64'(penable), 64'(0));
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        gap(1);

        issue(mk(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1'b0));
        gap(2);
        issue(mk(1'b1, 3'b001, 32'h4000_0024, 32'h1234_5678, 32'h0, 3, 1'b0));
        gap(2);
        issue(mk(1'b0, 3'b100, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 1, 1'b1));
        issue(mk(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 0, 1'b0));
        gap(1);
        issue(mk(1'b0, 3'b000, 32'hFFFF_0000, 32'h0, 32'h0BAD_0BAD, 0, 1'b0));
        gap(1);
        issue(mk(1'b1, 3'b100, 32'h0000_0200, 32'hA5A5_5A5A, 32'h0, 0, 1'b0));
        issue(mk(1'b0, 3'b001, 32'h0000_0204, 32'h0, 32'h0F0F_F0F0, 0, 1'b0));

        for (int i = 0; i < 80; i++) begin
            gap(int'($urandom_range(0, 2)));
            issue(rand_txn());
        end

`ifdef APB_TIMEOUT_EN
        gap(1);
        issue(mk(1'b0, 3'b001, 32'h0000_0300, 32'h0, 32'h1111_2222, 1000, 1'b0));
`endif

        // Reset in the middle of a waited ACCESS must abort without any response.
        gap(2);
        issue(mk(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h7777_8888, 10, 1'b0));
        n = 0;
        while (!penable && n < 20) begin
            @(negedge hclk);
            n++;
        end
        check("reset_reached_access", 64'(penable), 64'(1));
        #2;
        hresetn = 1'b0;
        #1;
        check("rst_mid_psel", 64'(psel), 64'(0));
        check("rst_mid_penable", 64'(penable), 64'(0));
        check("rst_mid_hreadyout", 64'(hreadyout), 64'(1));
        check("rst_mid_hrdata", 64'(hrdata), 64'(0));
        exp_q.delete();
        model_hrdata = '0;
        repeat (2) @(negedge hclk);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        gap(1);
        issue(mk(1'b1, 3'b010, 32'h0000_0500, 32'h9999_0000, 32'h0, 1, 1'b0));
        issue(mk(1'b0, 3'b010, 32'h0000_0504, 32'h0, 32'h2468_ACE0, 2, 1'b0));

        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge hclk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
        @(negedge hclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
